block_ram_fifo: RTL and testbench
=================================

Name: block_ram_fifo

Overview:
- First-word-fall-through FIFO built on the team's 1-read/1-write block RAM primitive (BlockDualPortRAM): registered read data, 1-cycle read latency, no read-during-write bypass.
- Handles the RAM's pointers, occupancy and stale-read hazard, and presents ready/valid on both sides.
- Used as a deep queue between pipeline stages, e.g. fetch buffer or store queue, where flop-based FIFOs are too large.

Parameters:
- ENTRY_NUM, 1024: FIFO depth; power of two, ≥2; forwarded to the RAM.
- ENTRY_BIT_SIZE, 32: data width; forwarded to the RAM.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  asynchronous reset, active-high
- inValid  input  1  producer offers inData
- inReady  output  1  FIFO can accept; push = inValid && inReady
- inData  input  ENTRY_BIT_SIZE  write data
- outValid  output  1  outData holds the head entry
- outReady  input  1  consumer takes head; pop = outValid && outReady
- outData  output  ENTRY_BIT_SIZE  head entry; driven directly by RAM rData
- count  output  $clog2(ENTRY_NUM+1)  entries currently stored

Behaviour:
- State: wrPtr and rdPtr, each $clog2(ENTRY_NUM) bits, wrap naturally mod ENTRY_NUM; count; stale flag.
- Reset (async, immediate): wrPtr=0, rdPtr=0, count=0, stale=0. Outputs: outValid=0, inReady=0 while rst is high, count=0. RAM contents are not reset.
- Reset mid-operation discards all entries. No output may depend on RAM contents until new pushes occur.
- RAM hookup:
  - wEnable=push, wAddr=wrPtr, wData=inData.
  - rAddr=rdPtr+1 when pop, else rdPtr (combinational next-head).
  - outData=rData.
- inReady = !rst && count<ENTRY_NUM. It is registered-state only, with no combinational path from outReady. When full, a simultaneous pop does not admit a push in the same cycle.
- Per edge:
  - push: wrPtr+1.
  - pop: rdPtr+1.
  - count += push − pop; push and pop in the same cycle leave count unchanged.
- stale hazard:
  - stale is set at an edge where push && wAddr==rAddr, otherwise cleared.
  - The RAM returns old data in that case. rAddr holds, so the next edge reads the fresh value.
- outValid = count!=0 && !stale.
- Latency:
  - Push into an empty FIFO at edge E0 gives outValid=1 in the cycle after E1 (2-edge latency).
  - With count≥2 the FIFO sustains one pop per cycle with a continuous outValid.
  - count==1 with push and pop at the same edge produces exactly one outValid=0 bubble cycle (stale), then the new entry.
- Stall: outValid && !outReady holds rdPtr. The head slot is occupied and cannot be written, so outData stays bit-stable until popped.
- pop while outValid=0 is impossible by definition; outReady is ignored then.
- Full: count==ENTRY_NUM, wrPtr==rdPtr, inReady=0.
- Empty: count==0, outValid=0, outData is don't-care.
- Assertions for the bench: count never exceeds ENTRY_NUM or underflows; outData stable during stall; data order preserved.

Test Plan:
- Reset, then push 0xA5A5_0001 at E0 with outReady=0 → outValid=0 after E0, =1 after E1 with outData=0xA5A5_0001, count=1. Data then holds stable for 10 stalled cycles.
- ENTRY_NUM=8: push 0..7 with outReady=0 → count=8, inReady=0. An extra inValid is not accepted. Drain with outReady=1 → 0..7 in order, one per cycle, then outValid=0, count=0.
- count=1 (head 0x11); same-cycle push 0x22 and pop → next cycle outValid=0 (bubble), following cycle outData=0x22, count=1.
- Continuous stream: push 1000 sequential values with count kept ≥2 and random outReady → all 1000 values received in order, with no drop or duplicate across 125 pointer wraps.
- Full FIFO with outReady=1 and inValid=1 → the pop occurs and the push is refused that cycle; the push is accepted on the next cycle, count returns to 8.
- Assert rst asynchronously mid-stream (count=5, between edges) → outValid, inReady and count go to 0 immediately. After release, a push of 0x33 appears 2 edges later with no stale data emitted.

Source files
------------

// File: rtl/block_ram_fifo_if.sv
// Ready/valid bundle between a producer, the block RAM FIFO and a consumer.
// The master side is whoever drives the FIFO; the slave side is the FIFO itself.
interface block_ram_fifo_if #(
    parameter int ENTRY_NUM      = 1024,
    parameter int ENTRY_BIT_SIZE = 32
);
    localparam int CW = $clog2(ENTRY_NUM + 1);

    logic                      inValid;
    logic                      inReady;
    logic [ENTRY_BIT_SIZE-1:0] inData;
    logic                      outValid;
    logic                      outReady;
    logic [ENTRY_BIT_SIZE-1:0] outData;
    logic [CW-1:0]             count;

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outData, count
    );

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outData, count
    );
endinterface

// File: rtl/block_ram_fifo.sv
// First-word-fall-through FIFO on top of a 1R/1W block RAM with registered read data.
// Tracks pointers, occupancy and the write-to-head stale-read hazard.
module BlockDualPortRAM #(
    parameter int ENTRY_NUM      = 1024,
    parameter int ENTRY_BIT_SIZE = 32
) (
    input  logic                         clk,
    input  logic                         wEnable,
    input  logic [$clog2(ENTRY_NUM)-1:0] wAddr,
    input  logic [ENTRY_BIT_SIZE-1:0]    wData,
    input  logic [$clog2(ENTRY_NUM)-1:0] rAddr,
    output logic [ENTRY_BIT_SIZE-1:0]    rData
);
    logic [ENTRY_BIT_SIZE-1:0] mem [ENTRY_NUM];

    // Read returns the pre-write contents when rAddr == wAddr on the same edge.
    always_ff @(posedge clk) begin
        if (wEnable) begin
            mem[wAddr] <= wData;
        end
        rData <= mem[rAddr];
    end
endmodule

module block_ram_fifo #(
    parameter int ENTRY_NUM      = 1024,
    parameter int ENTRY_BIT_SIZE = 32
) (
    input  logic clk,
    input  logic rst,
    block_ram_fifo_if.slave bus
);
    localparam int AW = $clog2(ENTRY_NUM);
    localparam int CW = $clog2(ENTRY_NUM + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(ENTRY_NUM);

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          stale_q, stale_d;

    logic          inReadyInt;
    logic          outValidInt;
    logic          push;
    logic          pop;
    logic [AW-1:0] rAddr;
    logic [ENTRY_BIT_SIZE-1:0] rData;

    assign inReadyInt  = !rst && (count_q != FULL_COUNT);
    assign outValidInt = (count_q != '0) && !stale_q;
    assign push        = bus.inValid && inReadyInt;
    assign pop         = outValidInt && bus.outReady;

    // Look ahead to the next head on a pop so rData already holds it after the edge.
    assign rAddr = pop ? rdPtr_q + AW'(1) : rdPtr_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        stale_d = push && (wrPtr_q == rAddr);
        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            stale_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            stale_q <= stale_d;
        end
    end

    BlockDualPortRAM #(
        .ENTRY_NUM      (ENTRY_NUM),
        .ENTRY_BIT_SIZE (ENTRY_BIT_SIZE)
    ) ram (
        .clk     (clk),
        .wEnable (push),
        .wAddr   (wrPtr_q),
        .wData   (bus.inData),
        .rAddr   (rAddr),
        .rData   (rData)
    );

    assign bus.inReady  = inReadyInt;
    assign bus.outValid = outValidInt;
    assign bus.outData  = rData;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_block_ram_fifo.sv
// Randomized and directed bench for block_ram_fifo against a queue-based model.
// An entry written at the same edge it becomes head stays invisible for one cycle.
module tb_block_ram_fifo;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] dataQ[$];
    logic             justPromoted;
    logic             lastPushed;
    logic             lastPopped;

    block_ram_fifo_if #(.ENTRY_NUM(DEPTH), .ENTRY_BIT_SIZE(WIDTH)) bus ();

    block_ram_fifo #(.ENTRY_NUM(DEPTH), .ENTRY_BIT_SIZE(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called just after a rising edge; checks outputs at the falling edge, then advances one edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
        int  sizeBefore;
        logic expValid;
        bus.inValid  = v;
        bus.inData   = d;
        bus.outReady = r;
        @(negedge clk);
        sizeBefore = dataQ.size();
        expValid   = (sizeBefore != 0) && !justPromoted;
        checkOutput("inReady", 32'(bus.inReady), 32'(sizeBefore < DEPTH));
        checkOutput("outValid", 32'(bus.outValid), 32'(expValid));
        if (expValid && bus.outValid) begin
            checkOutput("headData", bus.outData, dataQ[0]);
        end
        lastPushed = v && (sizeBefore < DEPTH);
        lastPopped = expValid && r;
        if (lastPopped) begin
            void'(dataQ.pop_front());
        end
        if (lastPushed) begin
            dataQ.push_back(d);
        end
        justPromoted = lastPushed && ((sizeBefore - (lastPopped ? 1 : 0)) == 0);
        @(posedge clk);
        #1;
        checkOutput("count", 32'(bus.count), 32'(dataQ.size()));
    endtask

    task automatic drainAll();
        int guard = 0;
        while (dataQ.size() != 0 && guard < 4 * DEPTH) begin
            applyStimulus(1'b0, '0, 1'b1);
            guard++;
        end
        checkOutput("drainDone", 32'(dataQ.size()), 32'd0);
    endtask

    initial begin
        int sent;
        int received;
        int cyc;
        logic v;
        rst          = 1'b1;
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.outReady = 1'b0;
        justPromoted = 1'b0;
        lastPushed   = 1'b0;
        lastPopped   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstInReady", 32'(bus.inReady), 32'd0);
        checkOutput("rstOutValid", 32'(bus.outValid), 32'd0);
        checkOutput("rstCount", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First push, then a long stall with the head held.
        applyStimulus(1'b1, 32'hA5A5_0001, 1'b0);
        repeat (11) applyStimulus(1'b0, '0, 1'b0);
        drainAll();

        // Fill to full, offer one extra word, then drain in order.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0);
        applyStimulus(1'b1, 32'h99, 1'b0);
        checkOutput("fullRefused", 32'(lastPushed), 32'd0);
        drainAll();
        applyStimulus(1'b0, '0, 1'b1);

        // Single entry with simultaneous push and pop gives one bubble.
        applyStimulus(1'b1, 32'h11, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);

        // Full with both sides active: the pop happens, the push waits a cycle.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h100 + WIDTH'(i), 1'b0);
        applyStimulus(1'b1, 32'h55, 1'b1);
        checkOutput("fullPopOnly", 32'(lastPushed), 32'd0);
        applyStimulus(1'b1, 32'h55, 1'b0);
        checkOutput("fullRefill", 32'(bus.count), 32'(DEPTH));
        drainAll();

        // Random stream of sequential values across many pointer wraps.
        sent = 0;
        received = 0;
        cyc = 0;
        while ((sent < 1000 || dataQ.size() != 0) && cyc < 20000) begin
            v = (sent < 1000) && ($urandom_range(0, 7) != 0);
            applyStimulus(v, WIDTH'(sent), $urandom_range(0, 3) != 0);
            if (lastPushed) sent++;
            if (lastPopped) received++;
            cyc++;
        end
        checkOutput("streamReceived", 32'(received), 32'd1000);

        // Asynchronous reset between edges with five entries stored.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + WIDTH'(i), 1'b0);
        bus.inValid = 1'b0;
        bus.outReady = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncOutValid", 32'(bus.outValid), 32'd0);
        checkOutput("asyncInReady", 32'(bus.inReady), 32'd0);
        checkOutput("asyncCount", 32'(bus.count), 32'd0);
        dataQ.delete();
        justPromoted = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h33, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("postResetPop", 32'(lastPopped), 32'd1);
        applyStimulus(1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
